// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state, the
// per-latch control bundle and the canned control patterns built from it.
package pipeline_stall_controller_pkg;

  localparam int REG_BITS = 5;
  typedef logic [REG_BITS-1:0] regbits_t;

  typedef enum logic [1:0] {RUN, DWAIT, LU_BUBBLE, HALTED} pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_HOLD  = '0;
  localparam pipe_ctrl_t CTRL_RUN   = 8'b11111_000;
  // Fetch miss and load-use share a pattern: front end holds, bubble into EX.
  localparam pipe_ctrl_t CTRL_FHOLD = 8'b00111_010;
  localparam pipe_ctrl_t CTRL_REDIR = 8'b11111_110;
  localparam pipe_ctrl_t CTRL_DREL  = 8'b00011_001;

  // Normal-advance decision once memory stalls and halt are ruled out.
  function automatic pipe_ctrl_t ctrl_advance(input logic ihit, input logic redirect);
    if (!ihit)         return CTRL_FHOLD;
    else if (redirect) return CTRL_REDIR;
    else               return CTRL_RUN;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_load_use.sv
// Load-use comparator: flags an ID-stage read of the register an EX-stage load
// is about to write. Register 0 never creates a dependency.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);

  assign load_use_o = ex_memread_i & (ex_rt_i != '0) &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline latch enable/flush sequencer (RUN/DWAIT/LU_BUBBLE/HALTED).
// Define PIPELINE_PERF_CNT_EN to add stall_cycles/flush_count counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int REG_W = $bits(regbits_t)
`ifdef PIPELINE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             redirect,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted
`ifdef PIPELINE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  pipe_ctrl_state_t state_q, state_d;
  logic             started_q;
  logic             load_use, dmem_pend;
  pipe_ctrl_t       ctrl;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_memread_i(ex_memread),
    .ex_rt_i     (ex_rt),
    .id_rs_i     (id_rs),
    .id_rt_i     (id_rt),
    .load_use_o  (load_use)
  );

  assign dmem_pend = (mem_dREN | mem_dWEN) & ~dhit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!started_q) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN, LU_BUBBLE: begin
          if (halt_mem)       state_d = HALTED;
          else if (dmem_pend) state_d = DWAIT;
          else if (state_q == RUN && ihit && !redirect && load_use) state_d = LU_BUBBLE;
          else                state_d = RUN;
        end
        DWAIT:   if (dhit) state_d = RUN;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_HOLD;
    if (!RST && started_q) begin
      case (state_q)
        RUN, LU_BUBBLE: begin
          if (halt_mem || dmem_pend) ctrl = CTRL_HOLD;
          else if (state_q == RUN && ihit && !redirect && load_use) ctrl = CTRL_FHOLD;
          else ctrl = ctrl_advance(ihit, redirect);
        end
        DWAIT: begin
          // EX was frozen through the wait, so a redirect is honoured here.
          if (dhit) ctrl = ihit ? ctrl_advance(1'b1, redirect) : CTRL_DREL;
        end
        default: ctrl = CTRL_HOLD;
      endcase
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign en_ifid     = ctrl.en_ifid;
  assign en_idex     = ctrl.en_idex;
  assign en_exmem    = ctrl.en_exmem;
  assign en_memwb    = ctrl.en_memwb;
  assign flush_ifid  = ctrl.flush_ifid;
  assign flush_idex  = ctrl.flush_idex;
  assign flush_exmem = ctrl.flush_exmem;
  assign halted      = (state_q == HALTED);

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             cnt_live;

  assign cnt_live = started_q & (state_q != HALTED);

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_live && !ctrl.pc_en     && stall_q != '1) stall_d = stall_q + 1'b1;
    if (cnt_live && ctrl.flush_ifid && flush_q != '1) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; expected control vectors are
// hand-derived constants, checked with immediate assertions each cycle.
module tb_pipeline_stall_controller;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, mem_dREN, mem_dWEN, ex_memread, redirect, halt_mem;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, halted;
`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  // {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem, halted}
  localparam logic [8:0] ZERO  = 9'b00000_000_0;
  localparam logic [8:0] NORM  = 9'b11111_000_0;
  localparam logic [8:0] FHOLD = 9'b00111_010_0;
  localparam logic [8:0] REDIR = 9'b11111_110_0;
  localparam logic [8:0] DREL  = 9'b00011_001_0;
  localparam logic [8:0] HALT  = 9'b00000_000_1;

  always #5 CLK = ~CLK;

  pipeline_stall_controller dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .redirect(redirect), .halt_mem(halt_mem),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .halted(halted)
`ifdef PIPELINE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, halted};
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic cyc;
    @(negedge CLK);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    RST = 1; ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_memread = 0;
    redirect = 0; halt_mem = 0; ex_rt = 0; id_rs = 0; id_rt = 0;

    cyc(); settle(); chk("rst_c0", ZERO);
    cyc(); settle(); chk("rst_c1", ZERO);
    cyc(); RST = 0; ihit = 1; settle(); chk("first_after_rst", ZERO);
    cyc(); settle(); chk("normal", NORM);

    // load-use on rs, then bubble cycle ignores a lingering match
    cyc(); ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; settle(); chk("lu_rs_stall", FHOLD);
    cyc(); settle(); chk("lu_bubble", NORM);
    cyc(); ex_rt = 5'd0; id_rs = 5'd0; settle(); chk("lu_r0_nostall", NORM);
    cyc(); ex_rt = 5'd3; id_rs = 5'd1; id_rt = 5'd3; settle(); chk("lu_rt_stall", FHOLD);
    cyc(); ex_memread = 0; settle(); chk("lu_rt_bubble", NORM);

    // data miss with a concurrent redirect: stall wins
    cyc(); mem_dREN = 1; dhit = 0; redirect = 1; settle(); chk("dw_0", ZERO);
    cyc(); redirect = 0; settle(); chk("dw_1", ZERO);
    cyc(); settle(); chk("dw_2", ZERO);
    cyc(); dhit = 1; ihit = 0; settle(); chk("dw_release_imiss", DREL);
    cyc(); mem_dREN = 0; dhit = 0; ihit = 1; settle(); chk("dw_after", NORM);

    cyc(); ihit = 0; settle(); chk("imiss", FHOLD);

    // redirect squashes the load-use consumer; no bubble state follows
    cyc(); ihit = 1; redirect = 1; ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
    settle(); chk("redir_over_lu", REDIR);
    cyc(); redirect = 0; settle(); chk("redir_then_run", FHOLD);
    cyc(); ex_memread = 0; settle(); chk("redir_lu_bubble", NORM);

    // halt
    cyc(); halt_mem = 1; settle(); chk("halt_req", ZERO);
    cyc(); halt_mem = 0; settle(); chk("halted", HALT);
    for (int i = 0; i < 10; i++) begin
      cyc();
      ihit = 1'($urandom); dhit = 1'($urandom); redirect = 1'($urandom);
      mem_dREN = 1'($urandom); ex_memread = 1'($urandom);
      settle(); chk($sformatf("halted_toggle%0d", i), HALT);
    end
    cyc(); RST = 1; ihit = 1; dhit = 0; redirect = 0; mem_dREN = 0; ex_memread = 0;
    cyc(); settle(); chk("halt_cleared_in_rst", ZERO);
    cyc(); RST = 0; settle(); chk("post_halt_first", ZERO);
    cyc(); settle(); chk("post_halt_norm", NORM);

`ifdef PIPELINE_PERF_CNT_EN
    cyc(); ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; settle(); chk("perf_lu", FHOLD);
    cyc(); ex_memread = 0; settle(); chk("perf_bubble", NORM);
    for (int i = 0; i < 4; i++) begin
      cyc(); ihit = 0; settle(); chk($sformatf("perf_imiss%0d", i), FHOLD);
    end
    cyc(); ihit = 1; settle();
    chk32("stall_cycles", stall_cycles, 32'd5);
    chk32("flush_count_0", flush_count, 32'd0);
    redirect = 1;
    cyc(); redirect = 0; settle();
    chk32("flush_count_1", flush_count, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
